// File: rtl/coin_pkg.sv
// Shared coin encodings and dispenser state type for the vending payout path.
package coin_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EJECT,
        DONE,
        FAULT
    } disp_state_e;

    // Value of a coin in 5-cent units.
    function automatic logic [1:0] coinUnits(input logic [1:0] coin);
        return (coin == COIN_10) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/coin_ack_timer.sv
// Saturating cycle counter used to detect a hopper that never acknowledges a coin.
module coin_ack_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count_q;

    assign expired = (count_q == W'(LIMIT));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + W'(1);
        end
    end

endmodule

// File: rtl/coin_change_dispenser.sv
// Greedy coin payout engine (dimes, then nickels) with hopper ack timeout.
// Define COIN_INVENTORY_EN to add per-type coin inventory counters and refill ports.
module coin_change_dispenser
    import coin_pkg::*;
#(
    parameter int AMT_W       = 4,
    parameter int ACK_TIMEOUT = 15
`ifdef COIN_INVENTORY_EN
    ,
    parameter int INV_W       = 8,
    parameter int INV_INIT_D  = 16,
    parameter int INV_INIT_N  = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             change_valid,
    input  logic [AMT_W-1:0] change_amt,
    output logic             change_ready,
    output logic [1:0]       coin_out,
    input  logic             hopper_ack,
    output logic             done,
    output logic             fault,
    input  logic             fault_clr,
    output logic [AMT_W-1:0] owed
`ifdef COIN_INVENTORY_EN
    ,
    input  logic             refill_valid,
    input  logic [INV_W-1:0] refill_d,
    input  logic [INV_W-1:0] refill_n
`endif
);

    disp_state_e      state_q, state_d;
    logic [AMT_W-1:0] owed_q, owed_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       coin_out_q, coin_out_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;

    logic ackTake;
    logic timerExpired;
    logic dimeAvail;
    logic nickelAvail;

    // An ack only counts once the coin is actually being presented.
    assign ackTake = (state_q == EJECT) && hopper_ack && (coin_out_q != COIN_NONE);

    coin_ack_timer #(.LIMIT(ACK_TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  ((state_q != EJECT) || ackTake),
        .enable (state_q == EJECT),
        .expired(timerExpired)
    );

`ifdef COIN_INVENTORY_EN
    logic [INV_W-1:0] dimes_q, dimes_d;
    logic [INV_W-1:0] nickels_q, nickels_d;

    // Decrement cannot underflow: a type is only ejected while its count is nonzero.
    function automatic logic [INV_W-1:0] invNext(input logic [INV_W-1:0] cur, input logic dec,
                                                 input logic [INV_W-1:0] add, input logic addEn);
        logic [INV_W:0] sum;
        sum = {1'b0, cur} - (INV_W + 1)'(dec) + (addEn ? {1'b0, add} : '0);
        return sum[INV_W] ? '1 : sum[INV_W-1:0];
    endfunction

    always_comb begin
        dimes_d   = invNext(dimes_q, ackTake && (sel_q == COIN_10), refill_d, refill_valid);
        nickels_d = invNext(nickels_q, ackTake && (sel_q == COIN_5), refill_n, refill_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dimes_q   <= INV_W'(INV_INIT_D);
            nickels_q <= INV_W'(INV_INIT_N);
        end else begin
            dimes_q   <= dimes_d;
            nickels_q <= nickels_d;
        end
    end

    assign dimeAvail   = (dimes_q != '0);
    assign nickelAvail = (nickels_q != '0);
`else
    assign dimeAvail   = 1'b1;
    assign nickelAvail = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        owed_d     = owed_q;
        sel_d      = sel_q;
        coin_out_d = COIN_NONE;
        case (state_q)
            IDLE: begin
                if (change_valid) begin
                    owed_d  = change_amt;
                    state_d = (change_amt == '0) ? DONE : SELECT;
                end
            end
            SELECT: begin
                if ((owed_q >= AMT_W'(2)) && dimeAvail) begin
                    sel_d   = COIN_10;
                    state_d = EJECT;
                end else if (nickelAvail) begin
                    sel_d   = COIN_5;
                    state_d = EJECT;
                end else begin
                    state_d = FAULT;
                end
            end
            EJECT: begin
                // Ack is checked before the timeout so a last-cycle ack still succeeds.
                if (ackTake) begin
                    owed_d  = owed_q - AMT_W'(coinUnits(sel_q));
                    state_d = (owed_d == '0) ? DONE : SELECT;
                end else if (timerExpired) begin
                    state_d = FAULT;
                end else begin
                    coin_out_d = sel_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            FAULT: begin
                if (fault_clr) begin
                    state_d = IDLE;
                    owed_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owed_q     <= '0;
            sel_q      <= COIN_NONE;
            coin_out_q <= COIN_NONE;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owed_q     <= owed_d;
            sel_q      <= sel_d;
            coin_out_q <= coin_out_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
        end
    end

    assign change_ready = ready_q;
    assign coin_out     = coin_out_q;
    assign done         = done_q;
    assign fault        = fault_q;
    assign owed         = owed_q;

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Directed bench for coin_change_dispenser: table of payout requests plus hand-written corner sequences.
module tb_coin_change_dispenser;
   import coin_pkg::*;

   localparam int ACK_TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       changeValid = 1'b0;
   logic [3:0] changeAmt = '0;
   logic       changeReady;
   logic [1:0] coinOut;
   logic       hopperAck = 1'b0;
   logic       done;
   logic       fault;
   logic       faultClr = 1'b0;
   logic [3:0] owed;
`ifdef COIN_INVENTORY_EN
   logic       refillValid = 1'b0;
   logic [7:0] refillD = '0;
   logic [7:0] refillN = '0;
`endif

   int testsRun = 0;
   int testsFailed = 0;

   always #5 clk = ~clk;

`ifdef COIN_INVENTORY_EN
   coin_change_dispenser #(.INV_INIT_D(0), .INV_INIT_N(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .change_valid(changeValid),
      .change_amt  (changeAmt),
      .change_ready(changeReady),
      .coin_out    (coinOut),
      .hopper_ack  (hopperAck),
      .done        (done),
      .fault       (fault),
      .fault_clr   (faultClr),
      .owed        (owed),
      .refill_valid(refillValid),
      .refill_d    (refillD),
      .refill_n    (refillN)
   );
`else
   coin_change_dispenser dut (
      .clk         (clk),
      .rst         (rst),
      .change_valid(changeValid),
      .change_amt  (changeAmt),
      .change_ready(changeReady),
      .coin_out    (coinOut),
      .hopper_ack  (hopperAck),
      .done        (done),
      .fault       (fault),
      .fault_clr   (faultClr),
      .owed        (owed)
   );
`endif

   typedef struct {
      logic [3:0] amt;
      int         ackDelay;
      int         expDimes;
      int         expNickels;
   } vec_t;

   vec_t vecs[7];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Issues one request and services every coin after ackDelay cycles until done, fault or budget.
   task automatic applyStimulus(input logic [3:0] amt, input int ackDelay,
                                output int nd, output int nn, output int sawDone);
      int budget;
      budget = 0;
      nd = 0;
      nn = 0;
      sawDone = 0;
      changeValid = 1'b1;
      changeAmt = amt;
      step();
      changeValid = 1'b0;
      while (sawDone == 0 && budget < 300 && !fault) begin
         if (done) begin
            sawDone = 1;
         end else if (coinOut != COIN_NONE) begin
            if (coinOut == COIN_10) nd++;
            else if (coinOut == COIN_5) nn++;
            else nn += 100;
            repeat (ackDelay) step();
            hopperAck = 1'b1;
            step();
            hopperAck = 1'b0;
            budget += ackDelay + 1;
         end else begin
            step();
            budget++;
         end
      end
   endtask

`ifdef COIN_INVENTORY_EN
   task automatic refillAll();
      refillValid = 1'b1;
      refillD = 8'd200;
      refillN = 8'd200;
      step();
      refillValid = 1'b0;
   endtask
`endif

   // Main directed sequence: reset checks, inventory corner, cycle-exact payouts, table sweep, faults and reset.
   initial begin
      int nd, nn, sawDone, cnt;

      vecs[0] = '{amt: 4'd3,  ackDelay: 0,  expDimes: 1, expNickels: 1};
      vecs[1] = '{amt: 4'd1,  ackDelay: 2,  expDimes: 0, expNickels: 1};
      vecs[2] = '{amt: 4'd2,  ackDelay: 0,  expDimes: 1, expNickels: 0};
      vecs[3] = '{amt: 4'd7,  ackDelay: 1,  expDimes: 3, expNickels: 1};
      vecs[4] = '{amt: 4'd15, ackDelay: 0,  expDimes: 7, expNickels: 1};
      vecs[5] = '{amt: 4'd4,  ackDelay: 14, expDimes: 2, expNickels: 0};
      vecs[6] = '{amt: 4'd0,  ackDelay: 0,  expDimes: 0, expNickels: 0};

      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      checkOutput("reset_ready", int'(changeReady), 1);
      checkOutput("reset_coin", int'(coinOut), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_fault", int'(fault), 0);
      checkOutput("reset_owed", int'(owed), 0);

`ifdef COIN_INVENTORY_EN
      // No dimes, one nickel: pay a nickel, then fault with one unit owed.
      changeValid = 1'b1;
      changeAmt = 4'd2;
      step();
      changeValid = 1'b0;
      step();
      step();
      checkOutput("inv_first_coin", int'(coinOut), int'(COIN_5));
      hopperAck = 1'b1;
      step();
      hopperAck = 1'b0;
      cnt = 0;
      while (!fault && cnt < 10) begin
         cnt++;
         step();
      end
      checkOutput("inv_fault", int'(fault), 1);
      checkOutput("inv_owed", int'(owed), 1);
      checkOutput("inv_coin_idle", int'(coinOut), 0);
      refillAll();
      checkOutput("inv_fault_sticky", int'(fault), 1);
      faultClr = 1'b1;
      step();
      faultClr = 1'b0;
      checkOutput("inv_clr_ready", int'(changeReady), 1);
      checkOutput("inv_clr_fault", int'(fault), 0);
      checkOutput("inv_clr_owed", int'(owed), 0);
`endif

      // Cycle-exact payout of 15c: dime at k+2, nickel two cycles after the ack.
      changeValid = 1'b1;
      changeAmt = 4'd3;
      step();
      changeValid = 1'b0;
      checkOutput("t1_ready_busy", int'(changeReady), 0);
      step();
      checkOutput("t1_coin_k1", int'(coinOut), 0);
      step();
      checkOutput("t1_coin_k2", int'(coinOut), int'(COIN_10));
      checkOutput("t1_owed_k2", int'(owed), 3);
      hopperAck = 1'b1;
      step();
      hopperAck = 1'b0;
      checkOutput("t1_coin_after_ack", int'(coinOut), 0);
      checkOutput("t1_owed_after_dime", int'(owed), 1);
      step();
      checkOutput("t1_coin_gap", int'(coinOut), 0);
      step();
      checkOutput("t1_coin_nickel", int'(coinOut), int'(COIN_5));
      hopperAck = 1'b1;
      step();
      hopperAck = 1'b0;
      checkOutput("t1_done", int'(done), 1);
      checkOutput("t1_owed_zero", int'(owed), 0);
      step();
      checkOutput("t1_done_pulse", int'(done), 0);
      checkOutput("t1_ready_after", int'(changeReady), 1);

      // Zero request completes immediately without a coin.
      changeValid = 1'b1;
      changeAmt = 4'd0;
      step();
      changeValid = 1'b0;
      checkOutput("t2_done", int'(done), 1);
      checkOutput("t2_coin", int'(coinOut), 0);
      step();
      checkOutput("t2_done_pulse", int'(done), 0);
      checkOutput("t2_ready", int'(changeReady), 1);

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].amt, vecs[i].ackDelay, nd, nn, sawDone);
         checkOutput($sformatf("vec%0d_dimes", i), nd, vecs[i].expDimes);
         checkOutput($sformatf("vec%0d_nickels", i), nn, vecs[i].expNickels);
         checkOutput($sformatf("vec%0d_done", i), sawDone, 1);
         step();
         checkOutput($sformatf("vec%0d_ready", i), int'(changeReady), 1);
         checkOutput($sformatf("vec%0d_owed", i), int'(owed), 0);
      end

      // No ack: the dime stays up ACK_TIMEOUT cycles, then a sticky fault.
      changeValid = 1'b1;
      changeAmt = 4'd2;
      step();
      changeValid = 1'b0;
      step();
      step();
      checkOutput("t3_coin", int'(coinOut), int'(COIN_10));
      cnt = 0;
      while (!fault && cnt < 100) begin
         cnt++;
         step();
      end
      checkOutput("t3_timeout_cycles", cnt, ACK_TIMEOUT);
      checkOutput("t3_fault", int'(fault), 1);
      checkOutput("t3_owed", int'(owed), 2);
      checkOutput("t3_coin_off", int'(coinOut), 0);
      hopperAck = 1'b1;
      changeValid = 1'b1;
      step();
      step();
      hopperAck = 1'b0;
      changeValid = 1'b0;
      checkOutput("t3_fault_sticky", int'(fault), 1);
      checkOutput("t3_owed_held", int'(owed), 2);
      faultClr = 1'b1;
      step();
      faultClr = 1'b0;
      checkOutput("t3_clr_ready", int'(changeReady), 1);
      checkOutput("t3_clr_fault", int'(fault), 0);
      checkOutput("t3_clr_owed", int'(owed), 0);

      // A new request during EJECT is ignored; ack/fault_clr in IDLE are ignored.
      changeValid = 1'b1;
      changeAmt = 4'd2;
      step();
      changeAmt = 4'd1;
      step();
      step();
      checkOutput("t5_coin", int'(coinOut), int'(COIN_10));
      checkOutput("t5_owed_kept", int'(owed), 2);
      checkOutput("t5_ready_busy", int'(changeReady), 0);
      changeValid = 1'b0;
      hopperAck = 1'b1;
      step();
      hopperAck = 1'b0;
      checkOutput("t5_done", int'(done), 1);
      step();
      hopperAck = 1'b1;
      faultClr = 1'b1;
      step();
      step();
      hopperAck = 1'b0;
      faultClr = 1'b0;
      checkOutput("t5_idle_ready", int'(changeReady), 1);
      checkOutput("t5_idle_coin", int'(coinOut), 0);
      checkOutput("t5_idle_owed", int'(owed), 0);
      checkOutput("t5_idle_done", int'(done), 0);

      // Reset in the middle of EJECT abandons the coin.
      changeValid = 1'b1;
      changeAmt = 4'd5;
      step();
      changeValid = 1'b0;
      step();
      step();
      checkOutput("t4_coin_before", int'(coinOut), int'(COIN_10));
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("t4_coin", int'(coinOut), 0);
      checkOutput("t4_ready", int'(changeReady), 1);
      checkOutput("t4_owed", int'(owed), 0);
      checkOutput("t4_fault", int'(fault), 0);
`ifdef COIN_INVENTORY_EN
      refillAll();
`endif
      applyStimulus(4'd5, 0, nd, nn, sawDone);
      checkOutput("t4_after_dimes", nd, 2);
      checkOutput("t4_after_nickels", nn, 1);
      checkOutput("t4_after_done", sawDone, 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
